// File: rtl/lb_arb_pkg.sv
// lb_arb_pkg: shared types and constants for the local-bus arbiter.
// Holds FSM state encoding, slot op codes and timeout defaults.
package lb_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } state_t;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;
  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/lb_arbiter_if.sv
// lb_arbiter_if: requester-side strobes and master local-bus signals.
// slave = arbiter view, master = requesters plus register-file view.
interface lb_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]            req_wr_en;
  logic [NUM_REQ-1:0]            req_rd_en;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_rd_vld;
  logic [DATA_WIDTH-1:0]         req_rd_data;
  logic                          req_rd_err;
  logic [NUM_REQ-1:0]            req_ovf;

  logic                          master_wr_en;
  logic                          master_rd_en;
  logic [ADDR_WIDTH-1:0]         master_addr;
  logic [DATA_WIDTH-1:0]         master_wr_data;
  logic                          master_rd_vld;
  logic [DATA_WIDTH-1:0]         master_rd_data;

  modport slave (
    input  req_wr_en, req_rd_en, req_addr, req_wr_data,
    input  master_rd_vld, master_rd_data,
    output req_ready, req_rd_vld, req_rd_data, req_rd_err,
    output req_ovf,
    output master_wr_en, master_rd_en, master_addr,
    output master_wr_data
  );

  modport master (
    output req_wr_en, req_rd_en, req_addr, req_wr_data,
    output master_rd_vld, master_rd_data,
    input  req_ready, req_rd_vld, req_rd_data, req_rd_err,
    input  req_ovf,
    input  master_wr_en, master_rd_en, master_addr,
    input  master_wr_data
  );

endinterface

// File: rtl/lb_rr_arbiter.sv
// lb_rr_arbiter: combinational round-robin pick of the first pending
// index after last_grant. Ports: pending, last_grant -> gnt, gnt_idx.
module lb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && pending[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/lb_arbiter.sv
// lb_arbiter: one-deep command slots per requester, round-robin issue
// onto the master bus, read tracking with timeout. Ports: axil_clk,
// axil_rst_n, bus (lb_arbiter_if.slave), timeout_cnt.
module lb_arbiter
  import lb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA =
    DATA_WIDTH'(TIMEOUT_DATA_DEF)
) (
  input  logic                axil_clk,
  input  logic                axil_rst_n,
  lb_arbiter_if.slave         bus,
  output logic [TO_CNT_W-1:0] timeout_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [NUM_REQ-1:0]    slot_vld;
  logic [NUM_REQ-1:0]    slot_op;
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_data [NUM_REQ];

  state_t                state;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         rd_owner;
  logic [15:0]           timer;
  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  grant;

  assign grant         = (state == IDLE) && (|slot_vld);
  assign bus.req_ready = ~slot_vld;

  lb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .pending    (slot_vld),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    logic                  strobe;
    logic                  vld_q;
    logic                  op_q;
    logic                  ovf_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    assign strobe = bus.req_wr_en[i] | bus.req_rd_en[i];

    // Capture and release are exclusive: capture needs an empty slot,
    // release needs a full one.
    always_ff @(posedge axil_clk or negedge axil_rst_n) begin
      if (!axil_rst_n) begin
        vld_q  <= 1'b0;
        op_q   <= OP_WR;
        ovf_q  <= 1'b0;
        addr_q <= '0;
        data_q <= '0;
      end else if (vld_q) begin
        if (strobe) ovf_q <= 1'b1;
        if (grant && gnt[i]) vld_q <= 1'b0;
      end else if (strobe) begin
        vld_q  <= 1'b1;
        op_q   <= bus.req_wr_en[i] ? OP_WR : OP_RD;
        addr_q <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_q <= bus.req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign slot_vld[i]    = vld_q;
    assign slot_op[i]     = op_q;
    assign slot_addr[i]   = addr_q;
    assign slot_data[i]   = data_q;
    assign bus.req_ovf[i] = ovf_q;
  end

  always_ff @(posedge axil_clk or negedge axil_rst_n) begin
    if (!axil_rst_n) begin
      state              <= IDLE;
      last_grant         <= IW'(NUM_REQ - 1);
      rd_owner           <= '0;
      timer              <= '0;
      bus.master_wr_en   <= 1'b0;
      bus.master_rd_en   <= 1'b0;
      bus.master_addr    <= '0;
      bus.master_wr_data <= '0;
      bus.req_rd_vld     <= '0;
      bus.req_rd_data    <= '0;
      bus.req_rd_err     <= 1'b0;
      timeout_cnt        <= '0;
    end else begin
      bus.master_wr_en <= 1'b0;
      bus.master_rd_en <= 1'b0;
      bus.req_rd_vld   <= '0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            bus.master_addr <= slot_addr[gnt_idx];
            last_grant      <= gnt_idx;
            timer           <= '0;
            if (slot_op[gnt_idx] == OP_RD) begin
              bus.master_rd_en <= 1'b1;
              rd_owner         <= gnt_idx;
              state            <= WAIT_RD;
            end else begin
              bus.master_wr_en   <= 1'b1;
              bus.master_wr_data <= slot_data[gnt_idx];
            end
          end
        end
        WAIT_RD: begin
          // Response beats the timeout when both land together.
          if (bus.master_rd_vld) begin
            bus.req_rd_vld  <= ONE << rd_owner;
            bus.req_rd_data <= bus.master_rd_data;
            bus.req_rd_err  <= 1'b0;
            state           <= IDLE;
          end else if (timer == 16'(RD_TIMEOUT)) begin
            bus.req_rd_vld  <= ONE << rd_owner;
            bus.req_rd_data <= TIMEOUT_DATA;
            bus.req_rd_err  <= 1'b1;
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
            state           <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_arbiter.sv
// tb_lb_arbiter: randomized scenarios for lb_arbiter checked against
// a queue-based transaction model of the bus and read returns.
module tb_lb_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [DW-1:0] TDATA = 32'hDEAD_BEEF;

  typedef struct {
    int            cyc;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mtx_t;

  typedef struct {
    int            cyc;
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
    logic          err;
  } rtx_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] timeout_cnt;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_g = N - 1;
  int          to_cnt = 0;
  mtx_t        mq[$];
  rtx_t        rq[$];

  lb_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  lb_arbiter #(
    .NUM_REQ      (N),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .RD_TIMEOUT   (TO),
    .TIMEOUT_DATA (TDATA)
  ) dut (
    .axil_clk    (clk),
    .axil_rst_n  (rst_n),
    .bus         (bus),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.master_wr_en || bus.master_rd_en)
      mq.push_back('{cyc, bus.master_wr_en, bus.master_addr,
                     bus.master_wr_data});
    if (|bus.req_rd_vld)
      rq.push_back('{cyc, bus.req_rd_vld, bus.req_rd_data,
                     bus.req_rd_err});
  end

  task automatic wait_rd_en(output int m, output bit seen);
    seen = 1'b0;
    m = 0;
    for (int w = 0; w < 12 && !seen; w++) begin
      if (bus.master_rd_en) begin
        seen = 1'b1;
        m = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic strobe_rd(input int r, input logic [AW-1:0] ad);
    @(negedge clk);
    bus.req_addr[r*AW +: AW] = ad;
    bus.req_rd_en = N'(1 << r);
    @(negedge clk);
    bus.req_rd_en = '0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.req_ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready got %b exp 111", bus.req_ready);
    end
    checks++;
    if (bus.master_wr_en !== 1'b0 || bus.master_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got wr=%b rd=%b exp 0",
               bus.master_wr_en, bus.master_rd_en);
    end
    checks++;
    if (bus.req_rd_vld !== '0 || bus.req_rd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd got vld=%b err=%b exp 0",
               bus.req_rd_vld, bus.req_rd_err);
    end
    checks++;
    if (bus.req_ovf !== '0 || timeout_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_ovf_to got ovf=%b to=%0d exp 0",
               bus.req_ovf, timeout_cnt);
    end
    checks++;
    if (bus.master_addr !== '0 || bus.master_wr_data !== '0 ||
        bus.req_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data got a=%h d=%h rd=%h exp 0",
               bus.master_addr, bus.master_wr_data, bus.req_rd_data);
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus.req_addr[0 +: AW]  = 16'h0010;
    bus.req_wr_data[0 +: DW] = 32'h1234_5678;
    bus.req_wr_en = 3'b001;
    @(negedge clk);
    bus.req_wr_en = '0;
    checks++;
    if (bus.req_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL sw_ready_low got %b exp 0", bus.req_ready[0]);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL sw_ready_high got %b exp 1", bus.req_ready[0]);
    end
    checks++;
    if (bus.master_wr_en !== 1'b1 || bus.master_addr !== 16'h0010 ||
        bus.master_wr_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sw_master got en=%b a=%h d=%h exp 1 0010 12345678",
               bus.master_wr_en, bus.master_addr, bus.master_wr_data);
    end
    @(negedge clk);
    checks++;
    if (bus.master_wr_en !== 1'b0 || bus.master_addr !== 16'h0010) begin
      errors++;
      $display("FAIL sw_pulse got en=%b a=%h exp 0 0010",
               bus.master_wr_en, bus.master_addr);
    end
    last_g = 0;
  endtask

  task automatic test_rr_writes(input int n, input logic [N-1:0] fm);
    for (int it = 0; it < n; it++) begin
      logic [N-1:0]  mask;
      int            order[$];
      int            c0;
      logic [AW-1:0] a[N];
      logic [DW-1:0] d[N];
      mask = (it < 2) ? fm : N'($urandom_range(1, (1 << N) - 1));
      for (int k = 1; k <= N; k++)
        if (mask[(last_g + k) % N]) order.push_back((last_g + k) % N);
      mq.delete();
      @(negedge clk);
      c0 = cyc;
      for (int i = 0; i < N; i++) begin
        a[i] = AW'($urandom);
        d[i] = $urandom;
        bus.req_addr[i*AW +: AW]    = a[i];
        bus.req_wr_data[i*DW +: DW] = d[i];
      end
      bus.req_wr_en = mask;
      @(negedge clk);
      bus.req_wr_en = '0;
      repeat (N + 3) @(negedge clk);
      checks++;
      if (mq.size() != order.size()) begin
        errors++;
        $display("FAIL rr_count mask=%b got %0d exp %0d",
                 mask, mq.size(), order.size());
      end
      foreach (order[k]) begin
        int g;
        g = order[k];
        if (k < mq.size()) begin
          checks++;
          if (mq[k].cyc != c0 + 2 + k || mq[k].wr !== 1'b1 ||
              mq[k].addr !== a[g] || mq[k].data !== d[g]) begin
            errors++;
            $display("FAIL rr_tx%0d got c=%0d wr=%b a=%h d=%h exp c=%0d a=%h d=%h",
                     k, mq[k].cyc, mq[k].wr, mq[k].addr, mq[k].data,
                     c0 + 2 + k, a[g], d[g]);
          end
        end
      end
      last_g = order[order.size() - 1];
    end
  endtask

  task automatic test_read();
    for (int it = 0; it < 8; it++) begin
      int            r;
      int            lat;
      int            m;
      bit            seen;
      logic [DW-1:0] d;
      logic [AW-1:0] ad;
      r   = (it == 0) ? 1 : $urandom_range(0, N - 1);
      lat = (it == 0) ? 3 : (it == 1) ? TO : $urandom_range(0, TO - 1);
      d   = (it == 0) ? 32'hCAFE_0001 : $urandom;
      ad  = (it == 0) ? 16'h0004 : AW'($urandom);
      mq.delete();
      rq.delete();
      strobe_rd(r, ad);
      wait_rd_en(m, seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rd_issue got no master_rd_en exp one");
      end else begin
        if (lat > 0) repeat (lat) @(negedge clk);
        bus.master_rd_vld  = 1'b1;
        bus.master_rd_data = d;
        @(negedge clk);
        bus.master_rd_vld  = 1'b0;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (mq.size() != 1 || rq.size() != 1) begin
        errors++;
        $display("FAIL rd_count got m=%0d r=%0d exp 1 1",
                 mq.size(), rq.size());
      end else begin
        checks++;
        if (mq[0].wr !== 1'b0 || mq[0].addr !== ad) begin
          errors++;
          $display("FAIL rd_master got wr=%b a=%h exp 0 %h",
                   mq[0].wr, mq[0].addr, ad);
        end
        checks++;
        if (rq[0].cyc != m + lat + 1 || rq[0].vld !== N'(1 << r) ||
            rq[0].data !== d || rq[0].err !== 1'b0) begin
          errors++;
          $display("FAIL rd_return lat=%0d got c=%0d v=%b d=%h e=%b exp c=%0d v=%b d=%h e=0",
                   lat, rq[0].cyc, rq[0].vld, rq[0].data, rq[0].err,
                   m + lat + 1, N'(1 << r), d);
        end
      end
      last_g = r;
    end
  endtask

  task automatic test_timeout();
    for (int it = 0; it < 2; it++) begin
      int  r;
      int  m;
      bit  seen;
      r = $urandom_range(0, N - 1);
      rq.delete();
      strobe_rd(r, AW'($urandom));
      wait_rd_en(m, seen);
      repeat (TO + 4) @(negedge clk);
      to_cnt++;
      checks++;
      if (!seen || rq.size() != 1) begin
        errors++;
        $display("FAIL to_count got seen=%0d r=%0d exp 1 1",
                 seen, rq.size());
      end else begin
        checks++;
        if (rq[0].cyc != m + TO + 1 || rq[0].vld !== N'(1 << r) ||
            rq[0].data !== TDATA || rq[0].err !== 1'b1) begin
          errors++;
          $display("FAIL to_return got c=%0d v=%b d=%h e=%b exp c=%0d v=%b d=%h e=1",
                   rq[0].cyc, rq[0].vld, rq[0].data, rq[0].err,
                   m + TO + 1, N'(1 << r), TDATA);
        end
      end
      checks++;
      if (timeout_cnt !== 16'(to_cnt)) begin
        errors++;
        $display("FAIL to_cnt got %0d exp %0d", timeout_cnt, to_cnt);
      end
      last_g = r;
    end
  endtask

  task automatic test_ovf();
    int            m;
    bit            seen;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    a1 = AW'($urandom);
    d1 = $urandom;
    mq.delete();
    rq.delete();
    strobe_rd(0, 16'h0020);
    wait_rd_en(m, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ovf_issue got no master_rd_en exp one");
    end
    bus.req_addr[0 +: AW]    = a1;
    bus.req_wr_data[0 +: DW] = d1;
    bus.req_wr_en = 3'b001;
    @(negedge clk);
    bus.req_addr[0 +: AW]    = ~a1;
    bus.req_wr_data[0 +: DW] = ~d1;
    @(negedge clk);
    bus.req_wr_en = '0;
    bus.master_rd_vld  = 1'b1;
    bus.master_rd_data = 32'h0BAD_F00D;
    @(negedge clk);
    bus.master_rd_vld  = 1'b0;
    checks++;
    if (bus.req_ovf !== 3'b001) begin
      errors++;
      $display("FAIL ovf_flag got %b exp 001", bus.req_ovf);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rq.size() != 1 || mq.size() != 2) begin
      errors++;
      $display("FAIL ovf_count got r=%0d m=%0d exp 1 2",
               rq.size(), mq.size());
    end else begin
      checks++;
      if (rq[0].cyc != m + 3 || rq[0].vld !== 3'b001 ||
          rq[0].data !== 32'h0BAD_F00D) begin
        errors++;
        $display("FAIL ovf_rd got c=%0d v=%b d=%h exp c=%0d v=001 d=0badf00d",
                 rq[0].cyc, rq[0].vld, rq[0].data, m + 3);
      end
      checks++;
      if (mq[1].cyc != m + 4 || mq[1].wr !== 1'b1 ||
          mq[1].addr !== a1 || mq[1].data !== d1) begin
        errors++;
        $display("FAIL ovf_wr got c=%0d wr=%b a=%h d=%h exp c=%0d a=%h d=%h",
                 mq[1].cyc, mq[1].wr, mq[1].addr, mq[1].data,
                 m + 4, a1, d1);
      end
    end
    last_g = 0;
  endtask

  task automatic test_reset_mid_read();
    int m;
    bit seen;
    mq.delete();
    rq.delete();
    strobe_rd(2, 16'h0040);
    wait_rd_en(m, seen);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.master_rd_vld  = 1'b1;
    bus.master_rd_data = 32'h5555_AAAA;
    @(negedge clk);
    bus.master_rd_vld  = 1'b0;
    repeat (TO + 4) @(negedge clk);
    last_g = N - 1;
    to_cnt = 0;
    checks++;
    if (!seen || mq.size() != 1 || rq.size() != 0) begin
      errors++;
      $display("FAIL rst_rd got seen=%0d m=%0d r=%0d exp 1 1 0",
               seen, mq.size(), rq.size());
    end
    checks++;
    if (bus.req_ready !== 3'b111 || bus.req_ovf !== '0 ||
        timeout_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_state got rdy=%b ovf=%b to=%0d exp 111 000 0",
               bus.req_ready, bus.req_ovf, timeout_cnt);
    end
    checks++;
    if (bus.master_addr !== '0 || bus.req_rd_data !== '0 ||
        bus.master_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_out got a=%h rd=%h en=%b exp 0",
               bus.master_addr, bus.req_rd_data, bus.master_rd_en);
    end
  endtask

  initial begin
    bus.req_wr_en      = '0;
    bus.req_rd_en      = '0;
    bus.req_addr       = '0;
    bus.req_wr_data    = '0;
    bus.master_rd_vld  = 1'b0;
    bus.master_rd_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_rr_writes(16, 3'b011);
    test_read();
    test_timeout();
    test_ovf();
    test_reset_mid_read();
    test_rr_writes(1, 3'b111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lb_arbiter.md
# lb_arbiter

Shares the single master local-bus port (`master_wr_en/rd_en/addr/wr_data`, `master_rd_vld/rd_data`) between `NUM_REQ` independent requesters, such as the serial command path and the JTAG-AXI bridge. Each requester gets a one-deep command slot with a ready flag. A round-robin scheduler issues one transaction at a time. Each read is tracked until it completes or times out, so reads from different requesters never collide. The block sits between the requester front-ends and the register-file decoder.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `ADDR_WIDTH`, 16, local-bus address width
- `DATA_WIDTH`, 32, local-bus data width
- `RD_TIMEOUT`, 255, cycles waited in WAIT_RD before a read is abandoned (1..65535)
- `TIMEOUT_DATA`, 32'hDEAD_BEEF, data returned on a timed-out read

Ports:
- `axil_clk`  in  1  sole clock
- `axil_rst_n`  in  1  reset; one clock, asynchronous, active-low
- `req_wr_en`  in  NUM_REQ  per-requester write strobe, one cycle
- `req_rd_en`  in  NUM_REQ  per-requester read strobe, one cycle
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i is at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_wr_data`  in  NUM_REQ*DATA_WIDTH  packed write data
- `req_ready`  out  NUM_REQ  slot empty, strobe will be accepted
- `req_rd_vld`  out  NUM_REQ  one-cycle read-return pulse
- `req_rd_data`  out  DATA_WIDTH  read data, shared; valid with any `req_rd_vld` bit
- `req_rd_err`  out  1  qualifies `req_rd_vld`: 1 = timed out
- `req_ovf`  out  NUM_REQ  sticky: a strobe arrived while the slot was full
- `master_wr_en`  out  1  write strobe
- `master_rd_en`  out  1  read strobe
- `master_addr`  out  ADDR_WIDTH  address
- `master_wr_data`  out  DATA_WIDTH  write data
- `master_rd_vld`  in  1  read-data valid
- `master_rd_data`  in  DATA_WIDTH  read data
- `timeout_cnt`  out  16  saturating count of timed-out reads

## Operation
- Slot capture:
  - A strobe with `req_ready` high is latched into slot i: op, addr, data.
  - If `wr_en` and `rd_en` arrive together, the write is taken and the read is discarded.
  - A strobe while the slot is full is dropped and sets `req_ovf[i]`.
- State machine: IDLE, WAIT_RD.
- IDLE:
  - If any slot is pending, `lb_rr_arbiter` grants the first pending index after `last_grant`, wrapping from NUM_REQ-1 to 0.
  - Registered master outputs are loaded and strobed for one cycle.
  - The slot is freed and `last_grant` is updated.
  - A write stays in IDLE. A read goes to WAIT_RD, latching the grant index into `rd_owner`.
- WAIT_RD:
  - The timer counts from 0.
  - On `master_rd_vld`: `req_rd_vld[rd_owner]` pulses next cycle with the captured data and `err=0`; the FSM returns to IDLE.
  - If the timer reaches RD_TIMEOUT without vld: `req_rd_vld[rd_owner]` pulses with TIMEOUT_DATA and `err=1`; `timeout_cnt` increments, saturating at 0xFFFF; the FSM returns to IDLE.
  - If vld and timeout occur in the same cycle, vld wins.
  - No new grant is made in WAIT_RD. Slots still accept strobes.
- `master_rd_vld` while in IDLE is ignored and nothing is forwarded.
- Reset: every output is 0, except `req_ready` which is all 1s. Slots empty, `last_grant` = NUM_REQ-1 (so requester 0 wins first), state IDLE, timer 0. Reset mid-read abandons the read silently.

## Timing
- Strobe accepted at edge E0:
  - `req_ready[i]` is low after E0.
  - The earliest grant is at E1; the master strobe is high for the cycle after E1.
  - `req_ready[i]` is high again after E1.
- Back-to-back writes from different slots give master strobes on consecutive cycles.
- Read latency to requester is master latency + 1 cycle. Timeout return is RD_TIMEOUT+1 cycles after the master_rd_en cycle.
- A strobe at slot i in the same cycle its slot frees is not accepted, because `req_ready` is registered.
- `master_addr` and `master_wr_data` hold their last value between strobes.

## Structure
- Package `lb_arb_pkg`: FSM state encoding, TIMEOUT_DATA default, an OP_WR/OP_RD slot-op constant, timeout counter width.
- Sub-module `lb_rr_arbiter`:
  - Inputs: pending vector and `last_grant`.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
- The pointer register stays in the top.

## Test plan
- Reset release, write 0x1234_5678 to 0x0010 from req0 → one `master_wr_en` pulse two cycles after the strobe, addr 0x0010, data matches; `req_ready[0]` returns high.
- req0 and req1 write in the same cycle → master order req0 then req1 on consecutive cycles; repeat → order req0, req1 again per round-robin.
- req1 reads 0x0004, model returns 0xCAFE_0001 after 3 cycles → `req_rd_vld[1]` pulses 1 cycle after `master_rd_vld`, `err=0`; `req_rd_vld[0]` stays 0.
- Read with no response and RD_TIMEOUT=8 → return 9 cycles after `master_rd_en` with 0xDEAD_BEEF, `err=1`, `timeout_cnt`=1.
- req0 strobes twice while its read is outstanding → second strobe dropped and `req_ovf[0]`=1; first queued command issues after read completion.
- Assert `axil_rst_n` low during WAIT_RD, then release → all outputs at reset values, no `req_rd_vld` pulse; the late `master_rd_vld` is ignored.
